// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and defaults for the pipeline stall/flush
// controller.
//   - mul_state_t : multiply sequencer states
//   - cause_t     : winning hazard cause selected by the priority mux
//   - *_DEF       : default parameter values for the controller
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned MUL_CYCLES_DEF = 2;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } mul_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_MEMWAIT,
        CAUSE_BRANCH,
        CAUSE_MUL,
        CAUSE_LOADUSE
    } cause_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_mul_seq.sv
// mul_seq: multiply occupancy sequencer for the EX stage.
// Ports:
//   clk, arst_n  - clock, asynchronous active-low reset
//   ex_is_mul    - instruction in EX is a multiply
//   freeze       - hold state and counter (data-memory wait)
//   abort        - return to IDLE (older taken branch flushes the multiply)
//   mul_start    - multiply accepted this cycle
//   stall_req    - front end must hold this cycle for the multiply
module mul_seq
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic ex_is_mul,
    input  logic freeze,
    input  logic abort,
    output logic mul_start,
    output logic stall_req
);

    // Acceptance cycle already stalls once, so MUL starts with two fewer.
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    mul_state_t state;
    logic [3:0] cnt;

    always_comb begin
        stall_req = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_req = ex_is_mul;
                mul_start = ex_is_mul & ~freeze & ~abort;
            end
            ST_MUL: begin
                stall_req = (cnt != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (!freeze) begin
            case (state)
                ST_IDLE: begin
                    if (ex_is_mul) begin
                        state <= ST_MUL;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_MUL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Ports:
//   clk, arst_n                 - clock, asynchronous active-low reset
//   id_rs1, id_rs2              - sources of the instruction in ID
//   ex_memread, ex_rd           - load flag / destination of the instruction in EX
//   ex_is_mul                   - instruction in EX is a multiply
//   mem_branch_taken            - taken branch in MEM
//   dmem_req, dmem_ready        - data-memory access / completion
//   stat_clr                    - synchronous clear of stall_cycles
//   pc_en .. memwb_en           - PC and pipeline register enables
//   ifid/idex/exmem_flush       - load a bubble at the next edge
//   mul_start, mul_busy         - multiply accepted / pipeline held for multiply
//   stall_cycles                - saturating count of cycles with pc_en=0
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_mul,
    input  logic                  mem_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  stat_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mul_start,
    output logic                  mul_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic   memwait;
    logic   load_use;
    logic   mul_stall_req;
    logic   mul_start_raw;
    cause_t cause;

    assign memwait  = dmem_req & ~dmem_ready;
    assign load_use = ex_memread & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A memory wait freezes everything, including a pending branch, so the
    // branch only aborts the multiply once the wait has cleared.
    mul_seq #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .clk       (clk),
        .arst_n    (arst_n),
        .ex_is_mul (ex_is_mul),
        .freeze    (memwait),
        .abort     (mem_branch_taken & ~memwait),
        .mul_start (mul_start_raw),
        .stall_req (mul_stall_req)
    );

    always_comb begin
        if (memwait)               cause = CAUSE_MEMWAIT;
        else if (mem_branch_taken) cause = CAUSE_BRANCH;
        else if (mul_stall_req)    cause = CAUSE_MUL;
        else if (load_use)         cause = CAUSE_LOADUSE;
        else                       cause = CAUSE_NONE;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mul_busy    = 1'b0;
        case (cause)
            CAUSE_MEMWAIT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            CAUSE_BRANCH: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            CAUSE_MUL: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                mul_busy    = 1'b1;
            end
            CAUSE_LOADUSE: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
        // Outputs are held inactive for the whole reset window.
        if (!arst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            mul_busy    = 1'b0;
        end
    end

    assign mul_start = mul_start_raw & arst_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles <= '0;
        end else if (stat_clr) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline with the 2-cycle multiplier. It drives the enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the bubble-insert (flush) controls. It handles four cases: data-memory wait, taken branches resolved in MEM, multi-cycle multiplies in EX, and load-use hazards. It also keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- MUL_CYCLES, 2, EX-stage occupancy of a multiply in cycles; legal values are 2..15
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_is_mul  in  1  instruction in EX is a multiply
- mem_branch_taken  in  1  branch in MEM is taken (membranch & zero)
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- stat_clr  in  1  synchronous clear of stall_cycles
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (all control bits 0) into the named register at the next edge
- mul_start  out  1  one-cycle pulse when a multiply is accepted in EX
- mul_busy  out  1  pipeline is held for a multiply
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating

## Operation
Conditions are evaluated in this priority order, highest first. Every enable defaults to 1 and every flush defaults to 0.
1. **MEMWAIT** (dmem_req & !dmem_ready)
   - All five enables are 0 and all flushes are 0.
   - The multiply FSM and its counter hold their state.
   - Any pending branch is re-evaluated in a later cycle.
2. **BRANCH** (mem_branch_taken)
   - All enables are 1 (the PC loads the target); ifid_flush, idex_flush and exmem_flush are 1.
   - The multiply FSM is forced to IDLE, because the multiply is younger than the branch.
   - mul_start is 0.
3. **MUL stall** (FSM holds the stall, see below)
   - pc_en, ifid_en and idex_en are 0; exmem_flush is 1; exmem_en and memwb_en are 1.
   - mul_busy is 1.
4. **LOAD-USE**, defined as ex_memread & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
   - pc_en and ifid_en are 0; idex_flush is 1.
   - All other enables are 1.

Multiply FSM (states IDLE and MUL; down-counter cnt of 4 bits):
- **IDLE**, with ex_is_mul=1 and no MEMWAIT or BRANCH:
  - Stall this cycle and pulse mul_start.
  - At the next edge, go to MUL with cnt=MUL_CYCLES-2.
- **MUL**, cnt≠0: stall, and decrement cnt.
- **MUL**, cnt==0: no stall, so the product advances to MEM. At the next edge, go to IDLE.
- A multiply therefore occupies EX for MUL_CYCLES cycles and the front end stalls for MUL_CYCLES-1 cycles.
- Back-to-back multiplies: the second one is seen in IDLE on the following cycle and is accepted normally.

stall_cycles:
- Increments by 1 at each edge where pc_en=0, saturating at all-ones.
- stat_clr has priority over the increment and sets the counter to 0.

## Timing
- All control outputs are combinational from the current inputs and registered state, with zero-cycle latency. They are valid before the same clock edge that the pipeline registers sample.
- State updates on the rising edge of clk.
- While arst_n=0:
  - The FSM is in IDLE, cnt=0 and stall_cycles=0.
  - All enables, flushes, mul_start and mul_busy are forced to 0.
- Release of arst_n: outputs follow the rules above from the first edge.
- Reset asserted mid-multiply aborts the multiply immediately; no mul_busy follows reset.
- A branch and a multiply in the same cycle: the branch wins, the FSM goes to IDLE and there is no mul_start.
- MEMWAIT during MUL: cnt does not decrement, so stall cycles due to the multiply are not consumed.
- A load-use hazard is masked while a multiply stall is active. It is re-evaluated when the stall ends, and is normally absent because a multiply is not a load.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the FSM state enum (IDLE, MUL);
  - defaults for REG_ADDR_W and MUL_CYCLES;
  - a cause encoding (NONE, MEMWAIT, BRANCH, MUL, LOADUSE) for the internal priority mux.
- One sub-module, mul_seq, contains the FSM, cnt, mul_start and the stall request. It has freeze and abort inputs.
- The top level contains the hazard compare, the priority mux and the stall counter.

## Test plan
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle
  - Required: pc_en=ifid_en=0 and idex_flush=1 that cycle; stall_cycles=1.
  - Repeat with ex_rd=0: no stall.
- **Multiply, MUL_CYCLES=2:** ex_is_mul=1
  - Required: mul_start and mul_busy for 1 cycle, then exmem_en=1 with no stall; stall_cycles +1.
  - Repeat with MUL_CYCLES=4: mul_busy for 3 cycles.
- **Branch mid-multiply:** mem_branch_taken=1 in the first MUL cycle
  - Required: all three flushes =1, all enables =1, mul_busy=0 on the next cycle, FSM in IDLE.
- **Memory wait:** dmem_req=1, dmem_ready=0 for 3 cycles during MUL with cnt=1
  - Required: all enables 0 for 3 cycles; after ready, 1 further mul_busy cycle.
- **Counter:** hold MEMWAIT for 2^CNT_W+3 cycles
  - Required: stall_cycles saturates at 0xFFFF; stat_clr=1 sets it to 0 at the next edge.
- **Reset mid-multiply:** assert arst_n=0 in MUL
  - Required: outputs 0 immediately; after release, mul_busy=0 and stall_cycles=0.
